// File: rtl/mem_line_responder.sv
// -----------------------------------------------------------------------------
// mem_line_responder
//
// Memory-side responder for a cache line-fill / write-back port. It holds a
// line-wide backing array and answers every accepted request with a one-cycle
// mem_res_ready pulse a fixed LATENCY cycles after the accepting edge.
//
// Optional feature macro: MEM_RESP_STATS_EN
//   defined   -> adds rd_count / wr_count saturating completion counters
//   undefined -> no counters, no extra ports
//
// Parameters
//   LATENCY      accept edge to ready pulse, in cycles (1..255)
//   DEPTH        number of lines in the backing array (power of 2)
//   BLOCK_WORDS  words per line; LINE_W = BLOCK_WORDS*WORD_WIDTH
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   mem_req_cs     in   request valid, held by the cache until mem_res_ready
//   mem_req_rw     in   0 = line read (fill), 1 = line write (write-back)
//   mem_req_addr   in   line address; low $clog2(DEPTH) bits index the array
//   mem_req_data   in   write line data
//   mem_res_ready  out  one-cycle completion pulse
//   mem_res_data   out  read line data, held until the next read completes
//   rd_count       out  (MEM_RESP_STATS_EN) completed reads, saturating
//   wr_count       out  (MEM_RESP_STATS_EN) completed writes, saturating
//
// Timing (request accepted on edge t0):
//   RESP is entered on edge t0+LATENCY-1; the array write / read-data capture
//   happens on that edge. mem_res_ready is registered on the edge that leaves
//   RESP, so it is high during [t0+LATENCY, t0+LATENCY+1). The cache only
//   reacts to the pulse on the following edge, so mem_req_cs is ignored while
//   mem_res_ready is high; a request still asserted in the cycle after the
//   pulse is accepted on the edge that ends that cycle.
// -----------------------------------------------------------------------------

package cache_parameters;
   parameter int WORD_WIDTH = 32;
   parameter int ADDR_WIDTH = 32;
endpackage

module mem_line_responder
   import cache_parameters::*;
#(
   parameter int LATENCY     = 4,
   parameter int DEPTH       = 1024,
   parameter int BLOCK_WORDS = 4,
   localparam int LINE_W     = BLOCK_WORDS * WORD_WIDTH,
   localparam int IDX_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_req_cs,
   input  logic                  mem_req_rw,
   input  logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic [LINE_W-1:0]     mem_req_data,
   output logic                  mem_res_ready,
   output logic [LINE_W-1:0]     mem_res_data
`ifdef MEM_RESP_STATS_EN
   ,
   output logic [15:0]           rd_count,
   output logic [15:0]           wr_count
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 32'sd1);
   localparam bit         LAT_ONE  = (LATENCY == 32'sd1);

   state_t              state_r;
   logic [7:0]          cnt_r;
   logic                rw_r;
   logic [IDX_W-1:0]    idx_r;
   logic [LINE_W-1:0]   wdata_r;

   // Backing store: not touched by rst, zero at time 0.
   logic [LINE_W-1:0]   mem_r [DEPTH] = '{default: '0};

   logic                accept_s;
   logic                enter_resp_s;
   logic                op_rw_s;
   logic [IDX_W-1:0]    op_idx_s;
   logic [LINE_W-1:0]   op_data_s;

   // Address bits above the index only alias lines; they carry no information.
   logic                unused_addr_s;
   assign unused_addr_s = ^mem_req_addr[ADDR_WIDTH-1:IDX_W];

   // A request is taken only in IDLE and never during the ready pulse itself.
   assign accept_s = (state_r == IDLE) && mem_req_cs && !mem_res_ready;

   // Detect the edge that enters RESP (directly from IDLE when LATENCY is 1).
   always_comb begin
      enter_resp_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s && LAT_ONE) begin
               enter_resp_s = 1'b1;
            end else begin
               enter_resp_s = 1'b0;
            end
         end
         WAIT: begin
            if (cnt_r == 8'd1) begin
               enter_resp_s = 1'b1;
            end else begin
               enter_resp_s = 1'b0;
            end
         end
         RESP:    enter_resp_s = 1'b0;
         default: enter_resp_s = 1'b0;
      endcase
   end

   // Operation fields: live inputs on the accepting edge, latched copies after.
   always_comb begin
      op_rw_s   = rw_r;
      op_idx_s  = idx_r;
      op_data_s = wdata_r;
      if (state_r == IDLE) begin
         op_rw_s   = mem_req_rw;
         op_idx_s  = mem_req_addr[IDX_W-1:0];
         op_data_s = mem_req_data;
      end else begin
         op_rw_s   = rw_r;
         op_idx_s  = idx_r;
         op_data_s = wdata_r;
      end
   end

   // Array write port; an aborted write never reaches RESP so it is dropped.
   always_ff @(posedge clk) begin
      if (enter_resp_s && op_rw_s) begin
         mem_r[op_idx_s] <= op_data_s;
      end
   end

   // Control FSM with registered ready pulse and read-data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= IDLE;
         cnt_r         <= 8'd0;
         rw_r          <= 1'b0;
         idx_r         <= '0;
         wdata_r       <= '0;
         mem_res_ready <= 1'b0;
         mem_res_data  <= '0;
      end else begin
         mem_res_ready <= 1'b0;
         if (enter_resp_s && !op_rw_s) begin
            mem_res_data <= mem_r[op_idx_s];
         end
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  rw_r    <= mem_req_rw;
                  idx_r   <= mem_req_addr[IDX_W-1:0];
                  wdata_r <= mem_req_data;
                  cnt_r   <= CNT_LOAD;
                  state_r <= LAT_ONE ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt_r <= cnt_r - 8'd1;
               if (cnt_r == 8'd1) begin
                  state_r <= RESP;
               end
            end
            RESP: begin
               mem_res_ready <= 1'b1;
               state_r       <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_RESP_STATS_EN
   // Saturating completion counters, stepped on the edge entering RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else begin
         if (enter_resp_s && !op_rw_s && (rd_count != 16'hFFFF)) begin
            rd_count <= rd_count + 16'd1;
         end
         if (enter_resp_s && op_rw_s && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end
`else
   // Statistics disabled: no counter state.
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_line_responder
//
// Two responders: u_l4 (LATENCY=4) and u_l1 (LATENCY=1). Directed requests
// push their hand-computed expected ready cycle and response data into a
// per-DUT queue; a negedge monitor pops and compares whenever ready is seen,
// and flags missing or spurious pulses.
// -----------------------------------------------------------------------------
module tb_mem_line_responder;
   import cache_parameters::*;

   localparam int LW = 4 * WORD_WIDTH;

   typedef struct {
      logic [LW-1:0] data;
      int            due;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [1:0]            cs;
   logic [1:0]            rw;
   logic [1:0]            rdy;
   logic [ADDR_WIDTH-1:0] addr  [2];
   logic [LW-1:0]         wdata [2];
   logic [LW-1:0]         rdata [2];
`ifdef MEM_RESP_STATS_EN
   logic [15:0]           rdc [2];
   logic [15:0]           wrc [2];
`endif

   exp_t q0[$];
   exp_t q1[$];
   int   tests  = 0;
   int   fails  = 0;
   int   edge_n = 0;

   localparam logic [LW-1:0] L17 = {32'hDEADBEEF, 32'h00000001, 32'h00000002, 32'h00000003};
   localparam logic [LW-1:0] L16 = {32'h16161616, 32'hCAFEF00D, 32'h00000000, 32'hFFFFFFFF};
   localparam logic [LW-1:0] LA5 = {4{32'hA5A5A5A5}};
   localparam logic [LW-1:0] L11 = {4{32'h11111111}};
   localparam logic [LW-1:0] LX  = {32'h0BAD0BAD, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F};
   localparam logic [LW-1:0] ZL  = '0;

   mem_line_responder #(.LATENCY(4), .DEPTH(1024), .BLOCK_WORDS(4)) u_l4 (
      .clk(clk), .rst(rst),
      .mem_req_cs(cs[0]), .mem_req_rw(rw[0]), .mem_req_addr(addr[0]), .mem_req_data(wdata[0]),
      .mem_res_ready(rdy[0]), .mem_res_data(rdata[0])
`ifdef MEM_RESP_STATS_EN
      , .rd_count(rdc[0]), .wr_count(wrc[0])
`endif
   );

   mem_line_responder #(.LATENCY(1), .DEPTH(1024), .BLOCK_WORDS(4)) u_l1 (
      .clk(clk), .rst(rst),
      .mem_req_cs(cs[1]), .mem_req_rw(rw[1]), .mem_req_addr(addr[1]), .mem_req_data(wdata[1]),
      .mem_res_ready(rdy[1]), .mem_res_data(rdata[1])
`ifdef MEM_RESP_STATS_EN
      , .rd_count(rdc[1]), .wr_count(wrc[1])
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic mon(input int d);
      exp_t e;
      int   n;
      n = (d == 0) ? q0.size() : q1.size();
      if (rdy[d]) begin
         if (n == 0) begin
            chk($sformatf("spurious_ready%0d", d), {{(LW-1){1'b0}}, rdy[d]}, ZL);
         end else begin
            if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk($sformatf("ready_cycle%0d", d), LW'(edge_n), LW'(e.due));
            chk($sformatf("res_data%0d", d), rdata[d], e.data);
         end
      end else if (n > 0) begin
         if (d == 0) e = q0[0]; else e = q1[0];
         if (edge_n > e.due) begin
            chk($sformatf("ready_timeout%0d", d), {{(LW-1){1'b0}}, rdy[d]}, {{(LW-1){1'b0}}, 1'b1});
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0);
         mon(1);
      end
   end

   // Issue one request, scramble inputs after accept, hold cs until the pulse.
   task automatic do_req(input int d, input bit w, input logic [ADDR_WIDTH-1:0] a,
                         input logic [LW-1:0] wd, input logic [LW-1:0] exp_rd, input int lat);
      exp_t e;
      bit   seen;
      seen     = 1'b0;
      cs[d]    = 1'b1;
      rw[d]    = w;
      addr[d]  = a;
      wdata[d] = wd;
      @(posedge clk); #1;
      e.data = exp_rd;
      e.due  = edge_n + lat;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      rw[d]    = ~w;
      addr[d]  = ~a;
      wdata[d] = ~wd;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (rdy[d]) seen = 1'b1;
      end
      @(posedge clk); #1;
      cs[d] = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst      = 1'b1;
      cs       = 2'b00;
      rw       = 2'b00;
      addr[0]  = '0;
      addr[1]  = '0;
      wdata[0] = '0;
      wdata[1] = '0;
      idle(3);
      chk("reset_ready0", {{(LW-1){1'b0}}, rdy[0]}, ZL);
      chk("reset_data0", rdata[0], ZL);
      chk("reset_ready1", {{(LW-1){1'b0}}, rdy[1]}, ZL);
      chk("reset_data1", rdata[1], ZL);
      rst = 1'b0;
      idle(2);

      // LATENCY=4: fill from zeroed array, write/read, back-to-back, wrap
      do_req(0, 1'b0, 32'h10, ZL, ZL, 4);
      idle(2);
      do_req(0, 1'b1, 32'h17, L17, ZL, 4);
      idle(1);
      do_req(0, 1'b0, 32'h17, ZL, L17, 4);
      idle(2);
      do_req(0, 1'b1, 32'h16, L16, L17, 4);
      do_req(0, 1'b0, 32'h16, ZL, L16, 4);
      idle(1);
      do_req(0, 1'b1, 32'h405, LA5, L16, 4);
      do_req(0, 1'b0, 32'h10, ZL, ZL, 4);
      do_req(0, 1'b0, 32'h005, ZL, LA5, 4);
      idle(2);
`ifdef MEM_RESP_STATS_EN
      chk("rd_count0", LW'(rdc[0]), LW'(16'd5));
      chk("wr_count0", LW'(wrc[0]), LW'(16'd3));
`endif

      // Reset in the middle of a write: no pulse, old contents survive
      cs[0]    = 1'b1;
      rw[0]    = 1'b1;
      addr[0]  = 32'h17;
      wdata[0] = L11;
      @(posedge clk); #1;
      cs[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_ready", {{(LW-1){1'b0}}, rdy[0]}, ZL);
      chk("midrst_data", rdata[0], ZL);
      idle(2);
      rst = 1'b0;
      idle(8);
      do_req(0, 1'b0, 32'h17, ZL, L17, 4);
      idle(1);
`ifdef MEM_RESP_STATS_EN
      chk("rd_count0_post", LW'(rdc[0]), LW'(16'd1));
      chk("wr_count0_post", LW'(wrc[0]), LW'(16'd0));
`endif

      // LATENCY=1: single-cycle response, wrap on back-to-back write/read
      do_req(1, 1'b0, 32'h10, ZL, ZL, 1);
      idle(1);
      do_req(1, 1'b1, 32'h3FF, LX, ZL, 1);
      do_req(1, 1'b0, 32'h7FF, ZL, LX, 1);
      idle(3);
`ifdef MEM_RESP_STATS_EN
      chk("rd_count1", LW'(rdc[1]), LW'(16'd2));
      chk("wr_count1", LW'(wrc[1]), LW'(16'd1));
`endif

      chk("pending0", LW'(q0.size()), ZL);
      chk("pending1", LW'(q1.size()), ZL);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
